branch_predictor_gshare: RTL and testbench



---
 rtl/bp_pkg.sv | 18 +
 rtl/sat_counter2.sv | 26 ++
 rtl/branch_predictor_gshare.sv | 123 ++++++++++++
 tb/tb_branch_predictor_gshare.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch-prediction lab: 2-bit saturating
// counter type, its named states and the direction decode.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT   = 2'd0;
    localparam ctr_t CTR_WNT   = 2'd1;
    localparam ctr_t CTR_WT    = 2'd2;
    localparam ctr_t CTR_ST    = 2'd3;
    localparam ctr_t CTR_RESET = CTR_WNT;

    // The upper counter bit is the predicted direction (1 = taken).
    function automatic logic ctr_taken(input ctr_t ctr);
        return ctr[1];
    endfunction

endpackage : bp_pkg

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating counter; purely combinational,
// clamps at CTR_SNT and CTR_ST instead of wrapping.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t ctr_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) begin
                ctr_o = ctr_i + 2'd1;
            end
        end else begin
            if (ctr_i != CTR_SNT) begin
                ctr_o = ctr_i - 2'd1;
            end
        end
    end

endmodule : sat_counter2

// File: rtl/branch_predictor_gshare.sv
// Table of 2-bit direction counters with a registered one-cycle response.
// Define GSHARE_HISTORY_EN to XOR a global history register into the index
// (gshare); leave it undefined for a PC-indexed bimodal predictor.
module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int p_entries   = 64,
    parameter int p_hist_bits = 6,
    localparam int IW         = $clog2(p_entries)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pred_val,
    input  logic [31:0]   pred_pc,
    output logic          resp_val,
    output logic          resp_taken,
    output logic [IW-1:0] resp_idx,
    input  logic          upd_val,
    input  logic [IW-1:0] upd_idx,
    input  logic          upd_taken
);

    ctr_t          ctr_q [p_entries];
    ctr_t          ctr_d;
    logic          ctr_we [p_entries];
    ctr_t          upd_ctr;

    logic [IW-1:0] pred_idx;

    logic          resp_val_q,   resp_val_d;
    logic          resp_taken_q, resp_taken_d;
    logic [IW-1:0] resp_idx_q,   resp_idx_d;

    // Only the word-aligned index bits of the PC select a counter.
    logic unused_pc;
    assign unused_pc = ^{pred_pc[31:IW+2], pred_pc[1:0]};

`ifdef GSHARE_HISTORY_EN
    logic [p_hist_bits-1:0] ghr_q, ghr_d;

    assign pred_idx = pred_pc[IW+1:2] ^ IW'(ghr_q);

    // History is non-speculative: it shifts only on resolved updates.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_val) begin
            ghr_d = (ghr_q << 1) | p_hist_bits'(upd_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    localparam int unused_hist_bits = p_hist_bits;

    assign pred_idx = pred_pc[IW+1:2];
`endif

    sat_counter2 u_upd_ctr (
        .ctr_i   (ctr_q[upd_idx]),
        .taken_i (upd_taken),
        .ctr_o   (upd_ctr)
    );

    always_comb begin
        ctr_d = upd_ctr;
        for (int i = 0; i < p_entries; i++) begin
            ctr_we[i] = upd_val && (upd_idx == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the whole table is reset here because every counter must
        // return to weak-not-taken in one reset cycle; plain RAM could not.
        if (reset) begin
            for (int i = 0; i < p_entries; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else begin
            for (int i = 0; i < p_entries; i++) begin
                if (ctr_we[i]) begin
                    ctr_q[i] <= ctr_d;
                end
            end
        end
    end

    // The table is read before this edge's write lands, so a same-cycle
    // update to the requested index is not visible in the response.
    always_comb begin
        resp_val_d   = pred_val;
        resp_taken_d = resp_taken_q;
        resp_idx_d   = resp_idx_q;
        if (pred_val) begin
            resp_taken_d = ctr_taken(ctr_q[pred_idx]);
            resp_idx_d   = pred_idx;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            resp_val_q   <= 1'b0;
            resp_taken_q <= 1'b0;
            resp_idx_q   <= '0;
        end else begin
            resp_val_q   <= resp_val_d;
            resp_taken_q <= resp_taken_d;
            resp_idx_q   <= resp_idx_d;
        end
    end

    assign resp_val   = resp_val_q;
    assign resp_taken = resp_taken_q;
    assign resp_idx   = resp_idx_q;

endmodule : branch_predictor_gshare

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare (64 entries, 6 history bits);
// table rows name target indices and the driver maps them to PCs.
module tb_branch_predictor_gshare;

    logic       clk = 1'b0;
    logic       reset;
    logic       pred_val;
    logic [31:0] pred_pc;
    logic       resp_val;
    logic       resp_taken;
    logic [5:0] resp_idx;
    logic       upd_val;
    logic [5:0] upd_idx;
    logic       upd_taken;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef GSHARE_HISTORY_EN
    logic [5:0] ghr_m = '0;
`endif

    always #5 clk = ~clk;

    branch_predictor_gshare #(.p_entries(64), .p_hist_bits(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .pred_val   (pred_val),
        .pred_pc    (pred_pc),
        .resp_val   (resp_val),
        .resp_taken (resp_taken),
        .resp_idx   (resp_idx),
        .upd_val    (upd_val),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken)
    );

    typedef struct {
        logic       pv;
        logic [5:0] pidx;
        logic       uv;
        logic [5:0] uidx;
        logic       ut;
        logic       e_val;
        logic       e_taken;
        logic [5:0] e_idx;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // PC whose index resolves to idx under the current (modelled) history.
    function automatic logic [31:0] pc_for(input logic [5:0] idx);
`ifdef GSHARE_HISTORY_EN
        return {24'b0, idx ^ ghr_m, 2'b00};
`else
        return {24'b0, idx, 2'b00};
`endif
    endfunction

    task automatic drive(input logic pv, input logic [31:0] pc,
                         input logic uv, input logic [5:0] ui, input logic ut);
        @(negedge clk);
        pred_val  = pv;
        pred_pc   = pc;
        upd_val   = uv;
        upd_idx   = ui;
        upd_taken = ut;
`ifdef GSHARE_HISTORY_EN
        if (uv && !reset) ghr_m = {ghr_m[4:0], ut};
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pred_val = 1'b0;
        upd_val  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
`ifdef GSHARE_HISTORY_EN
        ghr_m = '0;
`endif
    endtask

    task automatic expect_resp(input string name, input logic v, input logic t, input logic [5:0] i);
        check({name, ".val"},   32'(resp_val),   32'(v));
        check({name, ".taken"}, 32'(resp_taken), 32'(t));
        check({name, ".idx"},   32'(resp_idx),   32'(i));
    endtask

    task automatic pred_idx_chk(input string name, input logic [5:0] idx, input logic t);
        drive(1'b1, pc_for(idx), 1'b0, 6'd0, 1'b0);
        expect_resp(name, 1'b1, t, idx);
    endtask

    initial begin
        reset = 1'b1; pred_val = 1'b0; pred_pc = '0;
        upd_val = 1'b0; upd_idx = '0; upd_taken = 1'b0;

        //            pv  pidx  uv  uidx  ut  e_val e_tk e_idx
        vecs[0]  = '{1'b0, 6'h00, 1'b1, 6'h05, 1'b1, 1'b0, 1'b0, 6'h00};
        vecs[1]  = '{1'b0, 6'h00, 1'b1, 6'h05, 1'b1, 1'b0, 1'b0, 6'h00};
        vecs[2]  = '{1'b0, 6'h00, 1'b1, 6'h05, 1'b1, 1'b0, 1'b0, 6'h00};
        vecs[3]  = '{1'b1, 6'h05, 1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 6'h05};
        vecs[4]  = '{1'b0, 6'h00, 1'b1, 6'h05, 1'b0, 1'b0, 1'b1, 6'h05};
        vecs[5]  = '{1'b0, 6'h00, 1'b1, 6'h05, 1'b0, 1'b0, 1'b1, 6'h05};
        vecs[6]  = '{1'b1, 6'h05, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 6'h05};
        for (int k = 7; k <= 11; k++)
            vecs[k] = '{1'b0, 6'h00, 1'b1, 6'h0A, 1'b1, 1'b0, 1'b0, 6'h05};
        vecs[12] = '{1'b0, 6'h00, 1'b1, 6'h0A, 1'b0, 1'b0, 1'b0, 6'h05};
        vecs[13] = '{1'b1, 6'h0A, 1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 6'h0A};
        for (int k = 14; k <= 18; k++)
            vecs[k] = '{1'b0, 6'h00, 1'b1, 6'h0A, 1'b0, 1'b0, 1'b1, 6'h0A};
        vecs[19] = '{1'b1, 6'h0A, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 6'h0A};
        vecs[20] = '{1'b0, 6'h00, 1'b1, 6'h0A, 1'b1, 1'b0, 1'b0, 6'h0A};
        vecs[21] = '{1'b1, 6'h0A, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 6'h0A};
        vecs[22] = '{1'b1, 6'h03, 1'b1, 6'h03, 1'b1, 1'b1, 1'b0, 6'h03};
        vecs[23] = '{1'b1, 6'h03, 1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 6'h03};

        do_reset();
        expect_resp("reset", 1'b0, 1'b0, 6'h00);

        drive(1'b1, 32'h100, 1'b0, 6'd0, 1'b0);
        expect_resp("first_pred", 1'b1, 1'b0, 6'h00);

        for (int k = 0; k < 24; k++) begin
            drive(vecs[k].pv, pc_for(vecs[k].pidx), vecs[k].uv, vecs[k].uidx, vecs[k].ut);
            expect_resp($sformatf("vec%0d", k), vecs[k].e_val, vecs[k].e_taken, vecs[k].e_idx);
        end

        // History shift: outcomes 1,1,0 give ghr 0b000110.
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 6'h20, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 6'h21, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 6'h22, 1'b0);
        drive(1'b1, 32'h100, 1'b0, 6'd0, 1'b0);
`ifdef GSHARE_HISTORY_EN
        expect_resp("ghr_idx", 1'b1, 1'b0, 6'h06);
`else
        expect_resp("ghr_idx", 1'b1, 1'b0, 6'h00);
`endif

        // Mid-operation reset drops the request and ignores the update.
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 6'h10, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 6'h10, 1'b1);
        pred_idx_chk("pre_rst_10", 6'h10, 1'b1);
        @(negedge clk);
        reset     = 1'b1;
        pred_val  = 1'b1;
        pred_pc   = pc_for(6'h10);
        upd_val   = 1'b1;
        upd_idx   = 6'h11;
        upd_taken = 1'b1;
        @(posedge clk);
        #1;
        expect_resp("mid_reset", 1'b0, 1'b0, 6'h00);
        @(negedge clk);
        reset    = 1'b0;
        pred_val = 1'b0;
        upd_val  = 1'b0;
`ifdef GSHARE_HISTORY_EN
        ghr_m = '0;
`endif
        pred_idx_chk("post_rst_10", 6'h10, 1'b0);
        pred_idx_chk("post_rst_11", 6'h11, 1'b0);
        pred_idx_chk("post_rst_05", 6'h05, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_branch_predictor_gshare
